// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-lite multicycle control path: opcode and
// funct codes, ALU control encodings, datapath mux select encodings and the
// controller state enumeration.
// Optional feature macro: MC_BNE_EN (adds the BNEEX state for bne).
package mips_pkg;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, instr[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control encodings
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Coarse ALU operation requested by the controller from the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef MC_BNE_EN
        ,
        S_BNEEX   = 4'd12
`endif
    } state_e;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's coarse ALU op and the instruction funct
// field to a 3-bit ALU control word. The invalid-funct flag depends on funct
// alone so the controller can reject bad R-type instructions in DECODE,
// before the ALU op ever selects the funct path.
module mc_aludec
    import mips_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_invalid
);

    logic [2:0] funct_alu;

    // Translate funct into an ALU operation and flag unsupported codes
    always_comb begin
        funct_alu     = ALU_ADD;
        funct_invalid = 1'b0;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_invalid = 1'b1;
        endcase
    end

    // Select the final ALU control from the requested coarse operation
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_alu;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the MIPS-lite core with a single shared memory
// port. Sequences fetch, decode and execute states, stalls on mem_ready in
// FETCH, MEMRD and MEMWR, and drives Moore-style datapath strobes.
// Optional feature macro: MC_BNE_EN (decode bne into BNEEX).
module mc_controller
    import mips_pkg::*;
#(
    parameter bit MEM_WAIT_EN_DEFAULT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal
);

    state_e state_q;
    state_e state_d;
    state_e decode_next;
    aluop_e aluop;
    logic   decode_illegal;
    logic   funct_bad;
    logic   ready;

    // With waiting disabled the memory is treated as always ready
    assign ready = MEM_WAIT_EN_DEFAULT ? mem_ready : 1'b1;

    mc_aludec u_aludec (
        .aluop         (aluop),
        .funct         (funct),
        .alucontrol    (alucontrol),
        .funct_invalid (funct_bad)
    );

    // Opcode dispatch out of DECODE, including the illegal-instruction check
    always_comb begin
        decode_next    = S_FETCH;
        decode_illegal = 1'b0;
        case (op)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_RTYPE: begin
                if (funct_bad) decode_illegal = 1'b1;
                else           decode_next    = S_RTYPEEX;
            end
            OP_BEQ:  decode_next = S_BEQEX;
`ifdef MC_BNE_EN
            OP_BNE:  decode_next = S_BNEEX;
`endif
            OP_ADDI: decode_next = S_ADDIEX;
            OP_J:    decode_next = S_JEX;
            default: decode_illegal = 1'b1;
        endcase
    end

    // State register; synchronous reset returns the FSM to FETCH
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore control strobes; reset forces strobes off and FETCH selects
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        pcen       = 1'b0;
        irwrite    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                if (ready) begin
                    pcen    = 1'b1;
                    irwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_IMM_SH;
                state_d = decode_next;
                if (decode_illegal) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                pcen       = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                pcen       = ~zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JEX: begin
                pcsrc      = PCSRC_JUMP;
                pcen       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Abandon any instruction in flight; a pending memwrite drops this cycle
        if (reset) begin
            state_d    = S_FETCH;
            pcen       = 1'b0;
            irwrite    = 1'b0;
            iord       = 1'b0;
            memwrite   = 1'b0;
            memtoreg   = 1'b0;
            regdst     = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = SRCB_FOUR;
            pcsrc      = PCSRC_ALU;
            aluop      = ALUOP_ADD;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a table of instruction vectors with
// expected cycle counts, random instruction streams with random memory wait
// states, and a hand-built reset-during-store sequence. Expected per-cycle
// control words come from an instruction-level schedule model.
module tb_mc_controller;

    // Control word as seen by the datapath
    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       iord;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        int         fw;
        int         mw;
        int         cycles;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;

    logic       clk, reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pcen, irwrite, iord, memwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal;

    int checks = 0;
    int errors = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .iord(iord),
        .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .instr_done(instr_done),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t c;
        c.pcen = pcen; c.irwrite = irwrite; c.iord = iord; c.memwrite = memwrite;
        c.memtoreg = memtoreg; c.regdst = regdst; c.regwrite = regwrite;
        c.alusrca = alusrca; c.alusrcb = alusrcb; c.pcsrc = pcsrc;
        c.alucontrol = alucontrol; c.instr_done = instr_done; c.illegal = illegal;
        return c;
    endfunction

    // Everything off, ALU add
    function automatic ctl_t idle();
        ctl_t c = '0;
        c.alucontrol = 3'b010;
        return c;
    endfunction

    function automatic ctl_t fetch_word(input logic rdy);
        ctl_t c = idle();
        c.alusrcb = 2'b01;
        c.pcen    = rdy;
        c.irwrite = rdy;
        return c;
    endfunction

    function automatic ctl_t memadr_word();
        ctl_t c = idle();
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        return c;
    endfunction

    function automatic ctl_t memwr_word(input logic rdy);
        ctl_t c = idle();
        c.iord = 1'b1; c.memwrite = 1'b1; c.instr_done = rdy;
        return c;
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] alu_for(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
        if (o == RT) return funct_ok(f);
        if (o inside {LW, SW, BEQ, ADDI, JMP}) return 1'b1;
`ifdef MC_BNE_EN
        if (o == BNE) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // One cycle: drive inputs on the falling edge, compare shortly after
    task automatic step(input string name, input logic rst, input logic [5:0] o,
                        input logic [5:0] f, input logic z, input logic rdy,
                        input ctl_t exp, output ctl_t got);
        @(negedge clk);
        reset = rst; op = o; funct = f; zero = z; mem_ready = rdy;
        #1;
        got = sample();
        check(name, 32'(got), 32'(exp));
    endtask

    // Builds the expected cycle schedule of one instruction from its type and
    // wait counts, applies it, and reports the cycle in which instr_done fired.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int fw, input int mw, output int done_cycle);
        ctl_t exp_q[$];
        logic rdy_q[$];
        ctl_t c, got;
        for (int w = 0; w < fw; w++) begin exp_q.push_back(fetch_word(1'b0)); rdy_q.push_back(1'b0); end
        exp_q.push_back(fetch_word(1'b1)); rdy_q.push_back(1'b1);
        c = idle(); c.alusrcb = 2'b11;
        if (!is_legal(o, f)) begin
            c.illegal = 1'b1; c.instr_done = 1'b1;
            exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else begin
            exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
            if (o == LW || o == SW) begin
                exp_q.push_back(memadr_word()); rdy_q.push_back(1'($urandom_range(0, 1)));
                if (o == LW) begin
                    c = idle(); c.iord = 1'b1;
                    for (int w = 0; w <= mw; w++) begin exp_q.push_back(c); rdy_q.push_back(w == mw); end
                    c = idle(); c.regwrite = 1'b1; c.memtoreg = 1'b1; c.instr_done = 1'b1;
                    exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
                end else begin
                    for (int w = 0; w <= mw; w++) begin exp_q.push_back(memwr_word(w == mw)); rdy_q.push_back(w == mw); end
                end
            end else if (o == RT) begin
                c = idle(); c.alusrca = 1'b1; c.alucontrol = alu_for(f);
                exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
                c = idle(); c.regwrite = 1'b1; c.regdst = 1'b1; c.instr_done = 1'b1;
                exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
            end else if (o == BEQ || o == BNE) begin
                c = idle(); c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
                c.pcen = (o == BEQ) ? z : ~z; c.instr_done = 1'b1;
                exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
            end else if (o == ADDI) begin
                exp_q.push_back(memadr_word()); rdy_q.push_back(1'($urandom_range(0, 1)));
                c = idle(); c.regwrite = 1'b1; c.instr_done = 1'b1;
                exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
            end else begin
                c = idle(); c.pcsrc = 2'b10; c.pcen = 1'b1; c.instr_done = 1'b1;
                exp_q.push_back(c); rdy_q.push_back(1'($urandom_range(0, 1)));
            end
        end
        done_cycle = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            step($sformatf("%s cyc%0d", name, i + 1), 1'b0, o, f, z, rdy_q[i], exp_q[i], got);
            if (got.instr_done && done_cycle < 0) done_cycle = i + 1;
        end
    endtask

    initial begin
        vec_t  vecs[$];
        ctl_t  got;
        ctl_t  rst_word;
        int    done_cycle;
        logic [5:0] ops[8];

        rst_word = fetch_word(1'b0);
        reset = 1'b1; op = LW; funct = '0; zero = 1'b0; mem_ready = 1'b1;

        // Reset holds strobes off and FETCH selects regardless of inputs
        step("reset_a", 1'b1, LW, 6'b100000, 1'b1, 1'b1, rst_word, got);
        step("reset_b", 1'b1, SW, 6'b111111, 1'b0, 1'b1, rst_word, got);

        // Directed vectors with expected instruction lengths
        vecs.push_back('{LW,   6'b000000, 1'b0, 0, 0, 5});
        vecs.push_back('{SW,   6'b000000, 1'b0, 0, 0, 4});
        vecs.push_back('{RT,   6'b100000, 1'b0, 0, 0, 4});
        vecs.push_back('{RT,   6'b100010, 1'b0, 0, 0, 4});
        vecs.push_back('{RT,   6'b100100, 1'b1, 0, 0, 4});
        vecs.push_back('{RT,   6'b100101, 1'b0, 0, 0, 4});
        vecs.push_back('{RT,   6'b101010, 1'b0, 0, 0, 4});
        vecs.push_back('{BEQ,  6'b000000, 1'b1, 0, 0, 3});
        vecs.push_back('{BEQ,  6'b000000, 1'b0, 0, 0, 3});
        vecs.push_back('{ADDI, 6'b000000, 1'b0, 0, 0, 4});
        vecs.push_back('{JMP,  6'b000000, 1'b0, 0, 0, 3});
        vecs.push_back('{6'b111111, 6'b100000, 1'b0, 0, 0, 2});
        vecs.push_back('{RT,   6'b000000, 1'b0, 0, 0, 2});
`ifdef MC_BNE_EN
        vecs.push_back('{BNE,  6'b000000, 1'b0, 0, 0, 3});
`else
        vecs.push_back('{BNE,  6'b000000, 1'b0, 0, 0, 2});
`endif
        vecs.push_back('{SW,   6'b000000, 1'b0, 0, 3, 7});
        vecs.push_back('{LW,   6'b000000, 1'b0, 2, 1, 8});
        vecs.push_back('{BEQ,  6'b000000, 1'b1, 1, 0, 4});

        for (int i = 0; i < vecs.size(); i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].funct, vecs[i].z,
                      vecs[i].fw, vecs[i].mw, done_cycle);
            check($sformatf("vec%0d cycles", i), 32'(done_cycle), 32'(vecs[i].cycles));
        end

        // Reset asserted in a MEMWR wait cycle drops memwrite immediately
        step("rst_sw fetch",  1'b0, SW, 6'b0, 1'b0, 1'b1, fetch_word(1'b1), got);
        begin
            ctl_t c = idle();
            c.alusrcb = 2'b11;
            step("rst_sw decode", 1'b0, SW, 6'b0, 1'b0, 1'b0, c, got);
        end
        step("rst_sw memadr", 1'b0, SW, 6'b0, 1'b0, 1'b0, memadr_word(), got);
        step("rst_sw wait",   1'b0, SW, 6'b0, 1'b0, 1'b0, memwr_word(1'b0), got);
        step("rst_sw drop",   1'b1, SW, 6'b0, 1'b0, 1'b0, rst_word, got);
        check("rst_sw memwrite", 32'(got.memwrite), 32'd0);
        step("rst_sw hold",   1'b1, SW, 6'b0, 1'b0, 1'b1, rst_word, got);
        run_instr("after_rst", JMP, 6'b0, 1'b0, 0, 0, done_cycle);
        check("after_rst cycles", 32'(done_cycle), 32'd3);

        // Random instruction stream with random wait states
        ops = '{LW, SW, RT, BEQ, ADDI, JMP, BNE, 6'b000000};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] o, f;
            int k;
            k = $urandom_range(0, 7);
            o = (k == 7) ? 6'($urandom) : ops[k];
            f = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'b100000 + 6'($urandom_range(0, 2)) * 6'd2;
            if ($urandom_range(0, 3) == 0) f = 6'b101010;
            if ($urandom_range(0, 3) == 0) f = 6'b100101;
            run_instr($sformatf("rnd%0d", n), o, f, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2), done_cycle);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the MIPS-lite core, replacing the single-cycle decoder when instruction and data memory are merged into one memory port. It sequences a shared-memory datapath (IR, PC, one ALU, one memory port) through fetch, decode and execute states, and stalls on a memory ready handshake. Inputs come from the instruction register and ALU zero flag; outputs are registered-state (Moore) control strobes into the datapath.

## Interface
- `MEM_WAIT_EN_DEFAULT`, 1: when set, memory states honour `mem_ready`; when 0, `mem_ready` is treated as constant 1.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; state forced to FETCH.
- `op` in 6: instr[31:26] from IR.
- `funct` in 6: instr[5:0] from IR.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `pcen` out 1: PC load enable.
- `irwrite` out 1: IR load enable.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite` out 1: memory write strobe.
- `memtoreg` out 1: writeback select (1 = memory data).
- `regdst` out 1: destination select (1 = rd, 0 = rt).
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A select (0 = PC, 1 = rs).
- `alusrcb` out 2: ALU B select (00 rt, 01 const 4, 10 signimm, 11 signimm<<2).
- `pcsrc` out 2: next-PC select (00 ALU result, 01 ALUOut, 10 jump target).
- `alucontrol` out 3: ALU op (010 add, 110 sub, 000 and, 001 or, 111 slt).
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal` out 1: one-cycle pulse in DECODE on an unsupported opcode or funct.

## Operation
- States, 4-bit: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite and pcen are asserted only when `mem_ready`=1; otherwise the FSM stays in FETCH.
- DECODE: alusrca=0, alusrcb=11, add (computes branch target). Next state by op:
  - lw 100011 / sw 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - beq 000100 -> BEQEX
  - addi 001000 -> ADDIEX
  - j 000010 -> JEX
  - anything else -> FETCH with `illegal`=1 and `instr_done`=1.
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1. Holds until `mem_ready`, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. -> FETCH.
- MEMWR: iord=1, memwrite=1. memwrite is held until `mem_ready`, then -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, ALU op from funct (add, sub, and, or, slt). Any other funct: `illegal` pulse in DECODE, -> FETCH, RTYPEEX is not entered.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen=`zero`. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. ADDIWB: regwrite=1, regdst=0, memtoreg=0. -> FETCH.
- JEX: pcsrc=10, pcen=1. -> FETCH.
- Strobe defaults: every strobe not listed for a state is 0, and alucontrol defaults to 010.
- `instr_done` is asserted in the final state of each instruction, and only in the cycle it advances to FETCH.
- Reset: while `reset`=1, all strobes (pcen, irwrite, memwrite, regwrite, instr_done, illegal) are forced to 0, and mux selects take their FETCH values. The FSM is in FETCH on the first cycle after reset deasserts.
- Reset mid-instruction: the instruction is abandoned, and any pending memwrite is dropped in the same cycle.

## Timing
- State register updates on posedge clk. All outputs are combinational from state, plus op/funct/zero/mem_ready where stated. No output depends on `reset` other than through the forced-zero rule.
- Cycles per instruction with zero-wait memory:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each wait cycle on `mem_ready` adds exactly one cycle in FETCH, MEMRD or MEMWR.
- `mem_ready` asserted outside FETCH, MEMRD and MEMWR is ignored.

## Configuration
- `MC_BNE_EN`: when defined, opcode 000101 (bne) is decoded to a BNEEX state. BNEEX behaves like BEQEX except that pcen=`~zero`.
- When undefined, 000101 is an illegal opcode.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct localparams
  - alucontrol encodings
  - alusrcb and pcsrc select encodings
  - the state enumeration typedef
- Sub-module `mc_aludec` maps (aluop[1:0], funct) to alucontrol and an invalid-funct flag, and is instantiated once.

## Test plan
- Reset, then `mem_ready`=1 and op=100011: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5; `instr_done` in cycle 5 only.
- sw with `mem_ready` low for 3 cycles in MEMWR: memwrite is held high for 4 cycles, iord=1 throughout, and the FSM returns to FETCH after the ready cycle.
- R-type with funct=100010: alucontrol=110 in RTYPEEX, then regdst=1 and regwrite=1 in RTYPEWB; 4 cycles total.
- beq with zero=1 gives pcen=1 and pcsrc=01 in BEQEX; with zero=0, pcen=0; both cases take 3 cycles.
- op=111111, and separately R-type funct=000000: `illegal` pulses for 1 cycle in DECODE, the next state is FETCH, and no regwrite or memwrite occurs.
- Reset asserted in the MEMWR wait cycle: memwrite drops to 0 in that cycle, and FETCH is entered the following cycle with pcen=0 and irwrite=0 while reset is held.
